// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one single-port RAM (1-cycle read latency) between
// the Ibex instruction and data ports. Instruction fetch has priority; an
// aging counter forces a data grant after MAX_WAIT consecutive data denials.
// Out-of-window accesses are granted without touching the RAM and answered
// with an error response one cycle later.
// Optional feature macro: MEM_ARB_STATS_EN (grant counters and max stall).
module ibex_mem_arbiter #(
   parameter int unsigned MEM_SIZE  = 64 * 1024,
   parameter logic [31:0] MEM_START = 32'h0000_0000,
   parameter int unsigned MAX_WAIT  = 4
) (
   input  logic        clk_sys,
   input  logic        rst_sys_n,
   // instruction port
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   output logic        instr_err,
   // data port
   input  logic        data_req,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0] stat_instr_gnt,
   output logic [31:0] stat_data_gnt,
   output logic [3:0]  stat_data_stall_max,
`endif
   // RAM port
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] WIN_MASK   = ~(32'(MEM_SIZE) - 32'd1);
   localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

   // Outcome of the grant issued last cycle; selects who sees the response.
   typedef enum logic [2:0] {
      RESP_NONE  = 3'd0,
      RESP_I_OK  = 3'd1,
      RESP_I_ERR = 3'd2,
      RESP_D_OK  = 3'd3,
      RESP_D_ERR = 3'd4
   } resp_e;

   resp_e      resp_q, resp_d;
   logic       dwe_q, dwe_d;          // granted data access was a write
   logic [3:0] wait_cnt_q, wait_cnt_d;

   logic instr_in_win, data_in_win, data_win;

   assign instr_in_win = ((instr_addr & WIN_MASK) == MEM_START);
   assign data_in_win  = ((data_addr  & WIN_MASK) == MEM_START);
   // Data wins when instr is idle or data has aged out; reset blocks all grants.
   assign data_win     = rst_sys_n & data_req & (~instr_req | (wait_cnt_q == MAX_WAIT_C));

   // Arbitration, RAM drive, response next-state and aging next-state.
   always_comb begin
      instr_gnt  = 1'b0;
      data_gnt   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'h0;
      mem_addr   = 32'h0000_0000;
      mem_wdata  = 32'h0000_0000;
      resp_d     = RESP_NONE;
      dwe_d      = 1'b0;
      wait_cnt_d = 4'd0;

      if (data_win) begin
         data_gnt = 1'b1;
         dwe_d    = data_we;
         if (data_in_win) begin
            mem_req   = 1'b1;
            mem_we    = data_we;
            mem_be    = data_be;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            resp_d    = RESP_D_OK;
         end else begin
            resp_d    = RESP_D_ERR;
         end
      end else if (rst_sys_n && instr_req) begin
         instr_gnt = 1'b1;
         if (instr_in_win) begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = instr_addr;
            resp_d   = RESP_I_OK;
         end else begin
            resp_d   = RESP_I_ERR;
         end
      end else begin
         resp_d = RESP_NONE;
      end

      if (data_req && !data_gnt) begin
         wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : (wait_cnt_q + 4'd1);
      end else begin
         wait_cnt_d = 4'd0;
      end
   end

   // Response owner and aging counter registers.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         resp_q     <= RESP_NONE;
         dwe_q      <= 1'b0;
         wait_cnt_q <= 4'd0;
      end else begin
         resp_q     <= resp_d;
         dwe_q      <= dwe_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Route the response to the port that owned last cycle's grant.
   always_comb begin
      instr_rvalid = 1'b0;
      instr_err    = 1'b0;
      instr_rdata  = 32'h0000_0000;
      data_rvalid  = 1'b0;
      data_err     = 1'b0;
      data_rdata   = 32'h0000_0000;
      case (resp_q)
         RESP_I_OK: begin
            instr_rvalid = 1'b1;
            instr_rdata  = mem_rdata;
         end
         RESP_I_ERR: begin
            instr_rvalid = 1'b1;
            instr_err    = 1'b1;
         end
         RESP_D_OK: begin
            data_rvalid = 1'b1;
            data_rdata  = dwe_q ? 32'h0000_0000 : mem_rdata;
         end
         RESP_D_ERR: begin
            data_rvalid = 1'b1;
            data_err    = 1'b1;
         end
         default: begin
            instr_rvalid = 1'b0;
            data_rvalid  = 1'b0;
         end
      endcase
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_instr_gnt_q, stat_data_gnt_q;
   logic [3:0]  stat_stall_max_q;

   // Grant counters (free-running wrap) and high-water mark of the aging counter.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         stat_instr_gnt_q <= 32'd0;
         stat_data_gnt_q  <= 32'd0;
         stat_stall_max_q <= 4'd0;
      end else begin
         stat_instr_gnt_q <= stat_instr_gnt_q + {31'd0, instr_gnt};
         stat_data_gnt_q  <= stat_data_gnt_q + {31'd0, data_gnt};
         if (wait_cnt_q > stat_stall_max_q) begin
            stat_stall_max_q <= wait_cnt_q;
         end else begin
            stat_stall_max_q <= stat_stall_max_q;
         end
      end
   end

   assign stat_instr_gnt      = stat_instr_gnt_q;
   assign stat_data_gnt       = stat_data_gnt_q;
   assign stat_data_stall_max = stat_stall_max_q;
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed-vector bench for ibex_mem_arbiter with a small behavioural RAM.
module tb_ibex_mem_arbiter;

   logic        clk_sys = 1'b0;
   logic        rst_sys_n;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_rdata;
   logic        data_req, data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_instr_gnt, stat_data_gnt;
   logic [3:0]  stat_data_stall_max;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] ram [0:1023];

   always #5 clk_sys = ~clk_sys;

   ibex_mem_arbiter #(
      .MEM_SIZE (64 * 1024),
      .MEM_START(32'h0000_0000),
      .MAX_WAIT (4)
   ) dut (
      .clk_sys     (clk_sys),
      .rst_sys_n   (rst_sys_n),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_gnt   (instr_gnt),
      .instr_rvalid(instr_rvalid),
      .instr_rdata (instr_rdata),
      .instr_err   (instr_err),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_be     (data_be),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .data_err    (data_err),
`ifdef MEM_ARB_STATS_EN
      .stat_instr_gnt     (stat_instr_gnt),
      .stat_data_gnt      (stat_data_gnt),
      .stat_data_stall_max(stat_data_stall_max),
`endif
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Behavioural RAM: byte-enabled writes, read data one cycle after mem_req.
   always @(posedge clk_sys) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= ram[mem_addr[11:2]];
         end
      end
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'hA5A5_0000 | 32'(i);
      mem_rdata  = 32'h0;
      rst_sys_n  = 1'b0;
      instr_req  = 1'b0;
      instr_addr = 32'h0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_be    = 4'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      cycle();
      cycle();
      // Reset state
      check_vec("rst_instr_gnt",    {31'd0, instr_gnt},    32'd0);
      check_vec("rst_data_gnt",     {31'd0, data_gnt},     32'd0);
      check_vec("rst_instr_rvalid", {31'd0, instr_rvalid}, 32'd0);
      check_vec("rst_data_rvalid",  {31'd0, data_rvalid},  32'd0);
      check_vec("rst_mem_req",      {31'd0, mem_req},      32'd0);
      check_vec("rst_data_rdata",   data_rdata,            32'h0);
      rst_sys_n = 1'b1;
      cycle();

      // Instr-only fetch at 0x100 -> RAM word 0x40
      instr_req = 1'b1; instr_addr = 32'h0000_0100;
      #1;
      check_vec("if_gnt",     {31'd0, instr_gnt}, 32'd1);
      check_vec("if_dgnt",    {31'd0, data_gnt},  32'd0);
      check_vec("if_mem_req", {31'd0, mem_req},   32'd1);
      check_vec("if_mem_we",  {31'd0, mem_we},    32'd0);
      check_vec("if_mem_be",  {28'd0, mem_be},    32'hF);
      check_vec("if_mem_adr", mem_addr,           32'h0000_0100);
      cycle();
      instr_req = 1'b0;
      #1;
      check_vec("if_rvalid", {31'd0, instr_rvalid}, 32'd1);
      check_vec("if_rdata",  instr_rdata,           32'hA5A5_0040);
      check_vec("if_err",    {31'd0, instr_err},    32'd0);
      check_vec("if_drv",    {31'd0, data_rvalid},  32'd0);
      cycle();

      // Data write then read back at 0x200
      data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
      data_addr = 32'h0000_0200; data_wdata = 32'hDEAD_BEEF;
      #1;
      check_vec("dw_gnt",   {31'd0, data_gnt}, 32'd1);
      check_vec("dw_we",    {31'd0, mem_we},   32'd1);
      check_vec("dw_wdata", mem_wdata,         32'hDEAD_BEEF);
      cycle();
      data_we = 1'b0; data_wdata = 32'h0;
      #1;
      check_vec("dw_rvalid", {31'd0, data_rvalid}, 32'd1);
      check_vec("dw_rdata",  data_rdata,           32'h0);
      check_vec("dr_gnt",    {31'd0, data_gnt},    32'd1);
      cycle();
      data_req = 1'b0;
      #1;
      check_vec("dr_rvalid", {31'd0, data_rvalid}, 32'd1);
      check_vec("dr_rdata",  data_rdata,           32'hDEAD_BEEF);
      check_vec("dr_err",    {31'd0, data_err},    32'd0);
      cycle();

      // Contention: instr wins 4 cycles, data forced on the 5th
      instr_req = 1'b1; instr_addr = 32'h0000_0100;
      data_req  = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0200;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check_vec($sformatf("age_igt%0d", k), {31'd0, instr_gnt}, (k == 5) ? 32'd0 : 32'd1);
         check_vec($sformatf("age_dgt%0d", k), {31'd0, data_gnt},  (k == 5) ? 32'd1 : 32'd0);
         cycle();
      end
      data_req = 1'b0;
      #1;
      check_vec("age_drv",   {31'd0, data_rvalid}, 32'd1);
      check_vec("age_drd",   data_rdata,           32'hDEAD_BEEF);
      check_vec("age_iback", {31'd0, instr_gnt},   32'd1);
`ifdef MEM_ARB_STATS_EN
      check_vec("st_stall", {28'd0, stat_data_stall_max}, 32'd4);
`endif
      cycle();
      instr_req = 1'b0;
      cycle();

      // Out-of-window data read
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0001_0000;
      #1;
      check_vec("oow_gnt",  {31'd0, data_gnt}, 32'd1);
      check_vec("oow_mreq", {31'd0, mem_req},  32'd0);
      cycle();
      data_req = 1'b0;
      #1;
      check_vec("oow_rv",  {31'd0, data_rvalid}, 32'd1);
      check_vec("oow_err", {31'd0, data_err},    32'd1);
      check_vec("oow_rd",  data_rdata,           32'h0);
      cycle();

      // Out-of-window instr fetch
      instr_req = 1'b1; instr_addr = 32'h2000_0000;
      #1;
      check_vec("ioow_mreq", {31'd0, mem_req}, 32'd0);
      cycle();
      instr_req = 1'b0;
      #1;
      check_vec("ioow_err", {31'd0, instr_err}, 32'd1);
      check_vec("ioow_rd",  instr_rdata,        32'h0);
      cycle();

      // Partial write: 0xFFFFFFFF then be=0011 0x12345678 -> 0xFFFF5678
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0300;
      data_be = 4'hF; data_wdata = 32'hFFFF_FFFF;
      cycle();
      data_be = 4'b0011; data_wdata = 32'h1234_5678;
      cycle();
      data_we = 1'b0; data_be = 4'hF;
      cycle();
      data_req = 1'b0;
      #1;
      check_vec("pw_rd", data_rdata, 32'hFFFF_5678);
      cycle();

      // Reset asserted the cycle after a grant drops the response
      instr_req = 1'b1; instr_addr = 32'h0000_0100;
      #1;
      check_vec("rm_gnt", {31'd0, instr_gnt}, 32'd1);
      cycle();
      instr_req = 1'b0;
      rst_sys_n = 1'b0;
      #1;
      check_vec("rm_rv_in", {31'd0, instr_rvalid}, 32'd0);
`ifdef MEM_ARB_STATS_EN
      check_vec("rm_st_i", stat_instr_gnt, 32'd0);
      check_vec("rm_st_d", stat_data_gnt,  32'd0);
`endif
      cycle();
      rst_sys_n = 1'b1;
      cycle();
      check_vec("rm_rv_i", {31'd0, instr_rvalid}, 32'd0);
      check_vec("rm_rv_d", {31'd0, data_rvalid},  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
